// File: rtl/menu_pkg.sv
// Shared types and constants for the parametrised menu pixel generator.
package menu_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_HOVER   = 2'd1,
    BTN_PRESS   = 2'd2,
    BTN_LATCHED = 2'd3
  } btn_state_e;

  localparam int unsigned CNT_W         = 10;
  localparam int unsigned ADDR_W        = 17;
  localparam int unsigned RGB_W         = 12;
  localparam int unsigned SCREEN_W      = 320;
  localparam int unsigned SCREEN_PIXELS = 76800;
  localparam int unsigned CODE_OFFSET   = 2;

  localparam logic [RGB_W-1:0] C_BG_DEF    = 12'h000;
  localparam logic [RGB_W-1:0] C_FG_DEF    = 12'hFFF;
  localparam logic [RGB_W-1:0] C_TOUCH_DEF = 12'h32E;
  localparam logic [RGB_W-1:0] C_CLICK_DEF = 12'h3E2;
  localparam logic [RGB_W-1:0] C_LATCH_DEF = 12'h2F5;

  // Colour shown on a button's pixels for a given interaction state.
  function automatic logic [RGB_W-1:0] state_colour(
    input btn_state_e       s,
    input logic [RGB_W-1:0] c_bg,
    input logic [RGB_W-1:0] c_touch,
    input logic [RGB_W-1:0] c_click,
    input logic [RGB_W-1:0] c_latch
  );
    logic [RGB_W-1:0] c;
    case (s)
      BTN_HOVER:   c = c_touch;
      BTN_PRESS:   c = c_click;
      BTN_LATCHED: c = c_latch;
      default:     c = c_bg;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/menu_button_fsm.sv
// Per-button interaction FSM: idle/hover/press/latched with a registered
// one-cycle click pulse on release inside the button.
module menu_button_fsm
  import menu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hover,
  input  logic       mouse_left,
  input  logic       latch_set,
  input  logic       latch_clr,
  input  logic       toggle,
  output btn_state_e state,
  output logic       click_pulse
);

  btn_state_e state_q;
  logic       pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BTN_IDLE;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (latch_set) begin
        state_q <= BTN_LATCHED;
      end else begin
        case (state_q)
          BTN_LATCHED: if (latch_clr) state_q <= BTN_IDLE;
          // Entering with the button already held must not arm a click.
          BTN_IDLE:    if (hover && !mouse_left) state_q <= BTN_HOVER;
          BTN_HOVER: begin
            if (!hover)          state_q <= BTN_IDLE;
            else if (mouse_left) state_q <= BTN_PRESS;
          end
          BTN_PRESS: begin
            if (!hover) begin
              state_q <= BTN_IDLE;
            end else if (!mouse_left) begin
              pulse_q <= 1'b1;
              state_q <= toggle ? BTN_LATCHED : BTN_HOVER;
            end
          end
          default:     state_q <= BTN_IDLE;
        endcase
      end
    end
  end

  assign state       = state_q;
  assign click_pulse = pulse_q;

endmodule

// File: rtl/menu_button_pixel_gen.sv
// Menu-screen pixel generator: image address, 2-stage pixel pipeline and
// N_BUTTONS independent clickable regions.
module menu_button_pixel_gen
  import menu_pkg::*;
#(
  parameter int unsigned            N_BUTTONS   = 2,
  parameter int unsigned            MEM_W       = 3,
  parameter logic [N_BUTTONS-1:0]   TOGGLE_MASK = '0,
  parameter logic [RGB_W-1:0]       C_BG        = C_BG_DEF,
  parameter logic [RGB_W-1:0]       C_FG        = C_FG_DEF,
  parameter logic [RGB_W-1:0]       C_TOUCH     = C_TOUCH_DEF,
  parameter logic [RGB_W-1:0]       C_CLICK     = C_CLICK_DEF,
  parameter logic [RGB_W-1:0]       C_LATCH     = C_LATCH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CNT_W-1:0]         h_cnt,
  input  logic [CNT_W-1:0]         v_cnt,
  input  logic                     valid,
  input  logic                     mouse_left,
  input  logic [N_BUTTONS-1:0]     hover,
  input  logic [N_BUTTONS-1:0]     latch_set,
  input  logic [N_BUTTONS-1:0]     latch_clr,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [MEM_W-1:0]         mem_data,
  output logic [RGB_W-1:0]         pixel_out,
  output logic [N_BUTTONS-1:0]     click_pulse,
  output logic [2*N_BUTTONS-1:0]   btn_state
);

  // Wide enough for 511 + 320*511 before the wrap.
  localparam int unsigned SUM_W = 19;

  logic [SUM_W-1:0] addr_sum;
  btn_state_e       btn_st [N_BUTTONS];
  logic             valid_d1_q;
  logic [RGB_W-1:0] pixel_q;
  logic [RGB_W-1:0] pixel_d;

  assign addr_sum = SUM_W'(h_cnt >> 1) + SUM_W'(v_cnt >> 1) * SUM_W'(SCREEN_W);
  assign mem_addr = ADDR_W'(addr_sum % SUM_W'(SCREEN_PIXELS));

  for (genvar k = 0; k < N_BUTTONS; k++) begin : g_btn
    menu_button_fsm u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .hover       (hover[k]),
      .mouse_left  (mouse_left),
      .latch_set   (latch_set[k]),
      .latch_clr   (latch_clr[k]),
      .toggle      (TOGGLE_MASK[k]),
      .state       (btn_st[k]),
      .click_pulse (click_pulse[k])
    );
    assign btn_state[2*k +: 2] = btn_st[k];
  end

  // Stage-2 decode uses the button state as it stands before this edge.
  always_comb begin
    pixel_d = C_BG;
    if (valid_d1_q) begin
      if (mem_data == MEM_W'(1)) pixel_d = C_FG;
      for (int k = 0; k < int'(N_BUTTONS); k++) begin
        if (mem_data == MEM_W'(k + int'(CODE_OFFSET)))
          pixel_d = state_colour(btn_st[k], C_BG, C_TOUCH, C_CLICK, C_LATCH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d1_q <= 1'b0;
      pixel_q    <= C_BG;
    end else begin
      valid_d1_q <= valid;
      pixel_q    <= pixel_d;
    end
  end

  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_menu_button_pixel_gen.sv
// Directed bench: pixel table streamed through the pipeline plus hand-written
// button sequences on a 2-button (toggle on button 1) and a 5-button instance.
module tb_menu_button_pixel_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: 2 buttons, button 1 toggles.
  logic [9:0]  a_h, a_v;
  logic        a_valid, a_mouse;
  logic [1:0]  a_hover, a_lset, a_lclr, a_pulse;
  logic [16:0] a_addr;
  logic [2:0]  a_mdata;
  logic [11:0] a_pix;
  logic [3:0]  a_state;

  // Instance B: 5 buttons.
  logic [9:0]  b_h, b_v;
  logic        b_valid, b_mouse;
  logic [4:0]  b_hover, b_lset, b_lclr, b_pulse;
  logic [16:0] b_addr;
  logic [2:0]  b_mdata;
  logic [11:0] b_pix;
  logic [9:0]  b_state;

  menu_button_pixel_gen #(.N_BUTTONS(2), .MEM_W(3), .TOGGLE_MASK(2'b10)) u_a (
    .clk(clk), .rst_n(rst_n), .h_cnt(a_h), .v_cnt(a_v), .valid(a_valid),
    .mouse_left(a_mouse), .hover(a_hover), .latch_set(a_lset), .latch_clr(a_lclr),
    .mem_addr(a_addr), .mem_data(a_mdata), .pixel_out(a_pix),
    .click_pulse(a_pulse), .btn_state(a_state)
  );

  menu_button_pixel_gen #(.N_BUTTONS(5), .MEM_W(3), .TOGGLE_MASK(5'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .h_cnt(b_h), .v_cnt(b_v), .valid(b_valid),
    .mouse_left(b_mouse), .hover(b_hover), .latch_set(b_lset), .latch_clr(b_lclr),
    .mem_addr(b_addr), .mem_data(b_mdata), .pixel_out(b_pix),
    .click_pulse(b_pulse), .btn_state(b_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        valid;
    logic [2:0]  code;
    logic [16:0] addr;
    logic [11:0] pix;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{10'd101,  10'd51,   1'b1, 3'd1, 17'd8050,  12'hFFF};
    vecs[1] = '{10'd101,  10'd51,   1'b0, 3'd1, 17'd8050,  12'h000};
    vecs[2] = '{10'd0,    10'd0,    1'b1, 3'd0, 17'd0,     12'h000};
    vecs[3] = '{10'd639,  10'd479,  1'b1, 3'd1, 17'd76799, 12'hFFF};
    vecs[4] = '{10'd1023, 10'd1023, 1'b1, 3'd7, 17'd10431, 12'h000};
    vecs[5] = '{10'd640,  10'd0,    1'b1, 3'd2, 17'd320,   12'h000};
    vecs[6] = '{10'd2,    10'd960,  1'b1, 3'd3, 17'd1,     12'h000};
    vecs[7] = '{10'd639,  10'd0,    1'b1, 3'd1, 17'd319,   12'hFFF};

    rst_n = 1'b0;
    a_h = '0; a_v = '0; a_valid = 1'b0; a_mouse = 1'b0;
    a_hover = '0; a_lset = '0; a_lclr = '0; a_mdata = '0;
    b_h = '0; b_v = '0; b_valid = 1'b0; b_mouse = 1'b0;
    b_hover = '0; b_lset = '0; b_lclr = '0; b_mdata = '0;

    #2;
    chk("reset_pix_a",   32'(a_pix),   32'h000);
    chk("reset_state_a", 32'(a_state), 32'h0);
    chk("reset_pulse_a", 32'(a_pulse), 32'h0);
    chk("reset_state_b", 32'(b_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pixel table streamed one vector per cycle through the 2-stage pipeline.
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) chk($sformatf("pix_vec%0d", i - 2), 32'(a_pix), 32'(vecs[i-2].pix));
      if (i < NV) begin
        a_h = vecs[i].h; a_v = vecs[i].v; a_valid = vecs[i].valid;
      end
      if (i >= 1 && i - 1 < NV) a_mdata = vecs[i-1].code;
      #1;
      if (i < NV) chk($sformatf("addr_vec%0d", i), 32'(a_addr), 32'(vecs[i].addr));
      tick();
    end

    // Click on button 0 with code-2 pixels.
    a_valid = 1'b1; a_mdata = 3'd2; a_hover = 2'b01;
    tick();
    chk("click_hover_state", 32'(a_state[1:0]), 32'd1);
    chk("click_hover_pix",   32'(a_pix), 32'h000);
    a_mouse = 1'b1;
    tick();
    chk("click_press_state", 32'(a_state[1:0]), 32'd2);
    chk("click_press_pix",   32'(a_pix), 32'h32E);
    chk("click_press_pulse", 32'(a_pulse), 32'h0);
    tick();
    chk("click_hold_pix",    32'(a_pix), 32'h3E2);
    tick();
    chk("click_hold_state",  32'(a_state[1:0]), 32'd2);
    a_mouse = 1'b0;
    tick();
    chk("click_rel_state",   32'(a_state[1:0]), 32'd1);
    chk("click_rel_pulse",   32'(a_pulse), 32'h1);
    tick();
    chk("click_after_pulse", 32'(a_pulse), 32'h0);
    chk("click_after_pix",   32'(a_pix), 32'h32E);

    // Reset asynchronously mid-press; no pulse afterwards.
    a_mouse = 1'b1;
    tick();
    chk("pre_reset_state", 32'(a_state[1:0]), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pix",   32'(a_pix),   32'h000);
    chk("async_reset_state", 32'(a_state), 32'h0);
    chk("async_reset_pulse", 32'(a_pulse), 32'h0);
    a_mouse = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_state", 32'(a_state[1:0]), 32'd1);
    chk("post_reset_pulse", 32'(a_pulse), 32'h0);
    tick();
    chk("post_reset_pulse2", 32'(a_pulse), 32'h0);
    a_hover = 2'b00;
    tick();

    // Drag-off on button 1.
    a_hover = 2'b10;
    tick();
    chk("drag_hover", 32'(a_state[3:2]), 32'd1);
    a_mouse = 1'b1;
    tick();
    chk("drag_press", 32'(a_state[3:2]), 32'd2);
    a_hover = 2'b00;
    tick();
    chk("drag_off_state", 32'(a_state[3:2]), 32'd0);
    chk("drag_off_pulse", 32'(a_pulse), 32'h0);
    a_mouse = 1'b0;
    tick();
    chk("drag_rel_pulse", 32'(a_pulse), 32'h0);

    // Enter with button already held stays IDLE until release.
    a_mouse = 1'b1; a_hover = 2'b10;
    tick();
    chk("held_enter1", 32'(a_state[3:2]), 32'd0);
    tick();
    chk("held_enter2", 32'(a_state[3:2]), 32'd0);
    a_mouse = 1'b0;
    tick();
    chk("held_release", 32'(a_state[3:2]), 32'd1);

    // Toggle click on button 1 -> LATCHED.
    a_mdata = 3'd3; a_mouse = 1'b1;
    tick();
    a_mouse = 1'b0;
    tick();
    chk("toggle_state", 32'(a_state[3:2]), 32'd3);
    chk("toggle_pulse", 32'(a_pulse), 32'h2);
    tick();
    chk("latched_pix",   32'(a_pix), 32'h2F5);
    chk("latched_pulse", 32'(a_pulse), 32'h0);
    a_mouse = 1'b1;
    tick();
    chk("latched_mouse", 32'(a_state[3:2]), 32'd3);
    a_hover = 2'b00;
    tick();
    chk("latched_nohover", 32'(a_state[3:2]), 32'd3);
    a_mouse = 1'b0; a_lset = 2'b10; a_lclr = 2'b10;
    tick();
    chk("latch_set_wins", 32'(a_state[3:2]), 32'd3);
    a_lset = 2'b00;
    tick();
    chk("latch_clr", 32'(a_state[3:2]), 32'd0);
    a_lclr = 2'b00; a_lset = 2'b01;
    tick();
    chk("latch_set_idle", 32'(a_state), 32'h3);
    a_lset = 2'b00; a_lclr = 2'b01;
    tick();
    a_lclr = 2'b00;

    // Five buttons: code 6 is button 4, code 7 is out of range.
    b_valid = 1'b1; b_mdata = 3'd6; b_hover = 5'h1F;
    tick();
    chk("b_all_hover", 32'(b_state), 32'h155);
    b_mouse = 1'b1;
    tick();
    chk("b_all_press", 32'(b_state), 32'h2AA);
    chk("b_code6_pix", 32'(b_pix), 32'h32E);
    b_mouse = 1'b0;
    tick();
    chk("b_all_pulse", 32'(b_pulse), 32'h1F);
    chk("b_all_back",  32'(b_state), 32'h155);
    b_mdata = 3'd7;
    tick();
    chk("b_pulse_once", 32'(b_pulse), 32'h0);
    chk("b_code7_pix",  32'(b_pix), 32'h000);
    b_mdata = 3'd5;
    tick();
    chk("b_code5_pix",  32'(b_pix), 32'h32E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
